// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encoding and the
// writeback memory-port state type.
package alu_pkg;

  localparam int REG_WIDTH = 8;
  localparam int OP_WIDTH  = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND = 4'd0,
    OP_SLT = 4'd1,
    OP_OR  = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_SRL = 4'd5,
    OP_SRA = 4'd6,
    OP_BEQ = 4'd7,
    OP_MEM = 4'd8
  } op_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/wb_mem_port.sv
// Single-outstanding LW/SW port: holds the request until ack or timeout
// and captures load data for a one-cycle register-file write.
module wb_mem_port #(
  parameter int REG_WIDTH   = 8,
  parameter int RF_ADDR_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [REG_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0] wdata,
  input  logic [RF_ADDR_W-1:0] rd,
  input  logic                 mem_ack,
  input  logic [REG_WIDTH-1:0] mem_rdata,
  output logic                 busy,
  output logic                 timeout_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0] mem_wdata,
  output logic                 ld_we,
  output logic [RF_ADDR_W-1:0] ld_addr,
  output logic [REG_WIDTH-1:0] ld_data
);
  import alu_pkg::*;

  localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_e           state;
  logic [TIMER_W-1:0]   timer;
  logic                 is_load;
  logic [RF_ADDR_W-1:0] rd_q;

  assign busy = (state == MEM_WAIT);
  // An ack on the last allowed cycle takes priority over the timeout.
  assign timeout_hit = busy && !mem_ack && (timer == TIMER_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MEM_IDLE;
      timer     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_load   <= 1'b0;
      rd_q      <= '0;
      ld_we     <= 1'b0;
      ld_addr   <= '0;
      ld_data   <= '0;
    end else begin
      ld_we <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (start) begin
            state     <= MEM_WAIT;
            timer     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            is_load   <= !is_store;
            rd_q      <= rd;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state   <= MEM_IDLE;
            mem_req <= 1'b0;
            if (is_load) begin
              ld_we   <= 1'b1;
              ld_addr <= rd_q;
              ld_data <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= MEM_IDLE;
            mem_req <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage after the saturating ALU: result decode, flags, BEQ
// redirect with wrong-path squash, and the memory port.
module alu_writeback_stage #(
  parameter int REG_WIDTH   = 8,
  parameter int OP_WIDTH    = 4,
  parameter int RF_ADDR_W   = 3,
  parameter int PC_WIDTH    = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [OP_WIDTH-1:0]  ex_op,
  input  logic [REG_WIDTH-1:0] ex_res,
  input  logic [REG_WIDTH-1:0] ex_car,
  input  logic                 ex_zero,
  input  logic                 ex_jump,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic                 ex_is_store,
  input  logic [REG_WIDTH-1:0] ex_st_data,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [REG_WIDTH-1:0] ex_br_off,
  output logic                 wb_we,
  output logic [RF_ADDR_W-1:0] wb_addr,
  output logic [REG_WIDTH-1:0] wb_data,
  output logic                 car_we,
  output logic [REG_WIDTH-1:0] car_data,
  output logic                 zero_flag,
  output logic                 sat_flag,
  output logic                 br_taken,
  output logic [PC_WIDTH-1:0]  br_target,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [REG_WIDTH-1:0] mem_rdata,
  output logic                 err_flag
);
  import alu_pkg::*;

  op_e                  op;
  logic                 accept;
  logic                 live;
  logic                 mem_start;
  logic                 mem_busy;
  logic                 timeout_hit;
  logic [PC_WIDTH-1:0]  off_ext;
  logic                 alu_we;
  logic [RF_ADDR_W-1:0] alu_addr;
  logic [REG_WIDTH-1:0] alu_data;
  logic                 ld_we;
  logic [RF_ADDR_W-1:0] ld_addr;
  logic [REG_WIDTH-1:0] ld_data;

  assign op        = op_e'(ex_op);
  assign ex_ready  = !mem_busy;
  assign accept    = ex_valid && ex_ready;
  // The instruction behind a taken branch is wrong-path and is dropped.
  assign live      = accept && !br_taken;
  assign mem_start = live && (op == OP_MEM);
  assign off_ext   = PC_WIDTH'($signed(ex_br_off));

  assign wb_we   = alu_we | ld_we;
  assign wb_addr = ld_we ? ld_addr : alu_addr;
  assign wb_data = ld_we ? ld_data : alu_data;

  wb_mem_port #(
    .REG_WIDTH  (REG_WIDTH),
    .RF_ADDR_W  (RF_ADDR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_port (
    .clk        (clk),
    .reset      (reset),
    .start      (mem_start),
    .is_store   (ex_is_store),
    .addr       (ex_res),
    .wdata      (ex_st_data),
    .rd         (ex_rd),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (mem_busy),
    .timeout_hit(timeout_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_we    <= 1'b0;
      alu_addr  <= '0;
      alu_data  <= '0;
      car_we    <= 1'b0;
      car_data  <= '0;
      zero_flag <= 1'b0;
      sat_flag  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      err_flag  <= 1'b0;
    end else begin
      alu_we   <= 1'b0;
      car_we   <= 1'b0;
      br_taken <= 1'b0;
      if (live) begin
        case (op)
          OP_AND, OP_SLT, OP_OR, OP_SRL, OP_SRA: begin
            alu_we    <= 1'b1;
            alu_addr  <= ex_rd;
            alu_data  <= ex_res;
            zero_flag <= ex_zero;
          end
          OP_ADD, OP_SUB: begin
            alu_we    <= 1'b1;
            alu_addr  <= ex_rd;
            alu_data  <= ex_res;
            zero_flag <= ex_zero;
            car_we    <= 1'b1;
            car_data  <= ex_car;
            if (ex_car != '0) sat_flag <= 1'b1;
          end
          OP_BEQ: begin
            if (ex_jump) begin
              br_taken  <= 1'b1;
              br_target <= ex_pc + PC_WIDTH'(1) + off_ext;
            end
          end
          OP_MEM: begin
          end
          default: err_flag <= 1'b1;
        endcase
      end
      if (timeout_hit) err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage with hand-computed
// expectations for ALU writeback, branch/squash and memory access.
module tb_alu_writeback_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid;
  logic       ex_ready;
  logic [3:0] ex_op;
  logic [7:0] ex_res;
  logic [7:0] ex_car;
  logic       ex_zero;
  logic       ex_jump;
  logic [2:0] ex_rd;
  logic       ex_is_store;
  logic [7:0] ex_st_data;
  logic [9:0] ex_pc;
  logic [7:0] ex_br_off;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       car_we;
  logic [7:0] car_data;
  logic       zero_flag;
  logic       sat_flag;
  logic       br_taken;
  logic [9:0] br_target;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       err_flag;

  int tests_run    = 0;
  int tests_failed = 0;
  int req_cycles;

  alu_writeback_stage dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_op      (ex_op),
    .ex_res     (ex_res),
    .ex_car     (ex_car),
    .ex_zero    (ex_zero),
    .ex_jump    (ex_jump),
    .ex_rd      (ex_rd),
    .ex_is_store(ex_is_store),
    .ex_st_data (ex_st_data),
    .ex_pc      (ex_pc),
    .ex_br_off  (ex_br_off),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .car_we     (car_we),
    .car_data   (car_data),
    .zero_flag  (zero_flag),
    .sat_flag   (sat_flag),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] res,
                               input logic [7:0] car, input logic zero,
                               input logic jump, input logic [2:0] rd,
                               input logic is_store, input logic [7:0] st_data,
                               input logic [9:0] pc, input logic [7:0] off);
    ex_valid    = 1'b1;
    ex_op       = op;
    ex_res      = res;
    ex_car      = car;
    ex_zero     = zero;
    ex_jump     = jump;
    ex_rd       = rd;
    ex_is_store = is_store;
    ex_st_data  = st_data;
    ex_pc       = pc;
    ex_br_off   = off;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    idle();
    applyStimulus(4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 10'd0, 8'h00);
    idle();
    tick();
    tick();
    checkOutput("rst_ready", ex_ready, 1);
    checkOutput("rst_wb_we", wb_we, 0);
    checkOutput("rst_car_we", car_we, 0);
    checkOutput("rst_sat", sat_flag, 0);
    checkOutput("rst_err", err_flag, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_br_taken", br_taken, 0);
    reset = 1'b0;

    // ADD with overflow: write, carry side register, sticky saturation
    applyStimulus(4'd3, 8'd127, 8'd1, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("add_wb_we", wb_we, 1);
    checkOutput("add_wb_addr", wb_addr, 3);
    checkOutput("add_wb_data", wb_data, 127);
    checkOutput("add_car_we", car_we, 1);
    checkOutput("add_car_data", car_data, 1);
    checkOutput("add_sat", sat_flag, 1);
    tick();
    checkOutput("add_wb_we_pulse", wb_we, 0);
    checkOutput("add_car_we_pulse", car_we, 0);
    checkOutput("add_sat_sticky", sat_flag, 1);

    // AND, OR, SUB back to back
    applyStimulus(4'd0, 8'h0F, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    checkOutput("and_wb_we", wb_we, 1);
    checkOutput("and_wb_data", wb_data, 8'h0F);
    checkOutput("and_ready", ex_ready, 1);
    applyStimulus(4'd2, 8'hF0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    checkOutput("or_wb_we", wb_we, 1);
    checkOutput("or_wb_addr", wb_addr, 2);
    checkOutput("or_wb_data", wb_data, 8'hF0);
    checkOutput("or_ready", ex_ready, 1);
    applyStimulus(4'd4, 8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("sub_wb_we", wb_we, 1);
    checkOutput("sub_wb_addr", wb_addr, 4);
    checkOutput("sub_car_we", car_we, 1);
    checkOutput("sub_car_data", car_data, 0);
    checkOutput("sub_zero", zero_flag, 1);
    checkOutput("sub_sat_sticky", sat_flag, 1);
    tick();
    checkOutput("idle_wb_we", wb_we, 0);

    // Taken BEQ with negative offset, then a squashed wrong-path OR
    applyStimulus(4'd7, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 10'd10, 8'hFC);
    tick();
    checkOutput("beq_taken", br_taken, 1);
    checkOutput("beq_target", br_target, 7);
    checkOutput("beq_wb_we", wb_we, 0);
    applyStimulus(4'd2, 8'h11, 8'h00, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("squash_wb_we", wb_we, 0);
    checkOutput("squash_zero_kept", zero_flag, 1);
    checkOutput("beq_pulse_end", br_taken, 0);

    // Target wraps around the PC width
    applyStimulus(4'd7, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 10'd1023, 8'h00);
    tick();
    idle();
    checkOutput("wrap_taken", br_taken, 1);
    checkOutput("wrap_target", br_target, 0);
    tick();

    // Not-taken BEQ does not squash the next instruction
    applyStimulus(4'd7, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 10'd50, 8'h05);
    tick();
    checkOutput("nt_taken", br_taken, 0);
    applyStimulus(4'd5, 8'h22, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("nt_next_wb_we", wb_we, 1);
    checkOutput("nt_next_wb_data", wb_data, 8'h22);

    // LW with ack on the third request cycle
    applyStimulus(4'd8, 8'h20, 8'h00, 1'b0, 1'b0, 3'd6, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("lw_req_c1", mem_req, 1);
    checkOutput("lw_addr", mem_addr, 8'h20);
    checkOutput("lw_we", mem_we, 0);
    checkOutput("lw_ready_c1", ex_ready, 0);
    tick();
    checkOutput("lw_req_c2", mem_req, 1);
    checkOutput("lw_ready_c2", ex_ready, 0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    checkOutput("lw_req_c3", mem_req, 1);
    checkOutput("lw_ready_c3", ex_ready, 0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    checkOutput("lw_req_drop", mem_req, 0);
    checkOutput("lw_ready_back", ex_ready, 1);
    checkOutput("lw_wb_we", wb_we, 1);
    checkOutput("lw_wb_addr", wb_addr, 6);
    checkOutput("lw_wb_data", wb_data, 8'h5A);
    // Accept in the same cycle ex_ready returns
    applyStimulus(4'd0, 8'h33, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("post_lw_wb_we", wb_we, 1);
    checkOutput("post_lw_wb_data", wb_data, 8'h33);
    checkOutput("post_lw_wb_addr", wb_addr, 7);

    // Ack on the final allowed cycle wins over the timeout
    applyStimulus(4'd8, 8'h30, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    for (int i = 0; i < 14; i++) tick();
    checkOutput("late_ack_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 8'hA5;
    tick();
    mem_ack   = 1'b0;
    checkOutput("late_ack_wb_we", wb_we, 1);
    checkOutput("late_ack_wb_data", wb_data, 8'hA5);
    checkOutput("late_ack_err", err_flag, 0);
    checkOutput("late_ack_req_drop", mem_req, 0);

    // SW with no ack times out
    applyStimulus(4'd8, 8'h40, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h99, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("sw_we", mem_we, 1);
    checkOutput("sw_wdata", mem_wdata, 8'h99);
    checkOutput("sw_addr", mem_addr, 8'h40);
    req_cycles = 0;
    if (mem_req) req_cycles++;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_req) req_cycles++;
      if (wb_we) req_cycles += 100;
    end
    checkOutput("sw_req_cycles", req_cycles, 15);
    checkOutput("sw_err_before", err_flag, 0);
    tick();
    checkOutput("sw_to_req", mem_req, 0);
    checkOutput("sw_to_err", err_flag, 1);
    checkOutput("sw_to_wb_we", wb_we, 0);
    checkOutput("sw_to_ready", ex_ready, 1);

    // Reset while waiting on memory
    applyStimulus(4'd8, 8'h50, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("rw_req", mem_req, 1);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'h77;
    checkOutput("rw_req_clr", mem_req, 0);
    checkOutput("rw_ready", ex_ready, 1);
    checkOutput("rw_err_clr", err_flag, 0);
    checkOutput("rw_sat_clr", sat_flag, 0);
    checkOutput("rw_wb_we", wb_we, 0);
    // Stray ack while idle has no effect
    tick();
    mem_ack = 1'b0;
    checkOutput("stray_ack_wb_we", wb_we, 0);
    checkOutput("stray_ack_req", mem_req, 0);

    // Illegal opcode
    applyStimulus(4'd9, 8'h12, 8'h01, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 10'd0, 8'h00);
    tick();
    idle();
    checkOutput("ill_err", err_flag, 1);
    checkOutput("ill_wb_we", wb_we, 0);
    checkOutput("ill_car_we", car_we, 0);
    tick();
    checkOutput("ill_err_sticky", err_flag, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
